// File: rtl/count_cmd_scheduler.sv
// Converts up/down request levels into one-cycle counter commands with press-and-hold
// auto-repeat and conflict blocking. Define COUNT_CMD_ACCEL_EN for repeat acceleration.
module count_cmd_scheduler #(
  parameter int DELAY_CYC   = 2500000,
  parameter int RPT_CYC     = 500000,
  parameter int TMR_W       = 22,
  parameter int ACCEL_AFTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic up_req,
  input  logic dn_req,
  output logic up_cmd,
  output logic dn_cmd,
  output logic busy,
  output logic rpt_active
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HOLD_UP = 3'd1;
  localparam logic [2:0] HOLD_DN = 3'd2;
  localparam logic [2:0] RPT_UP  = 3'd3;
  localparam logic [2:0] RPT_DN  = 3'd4;
  localparam logic [2:0] BLOCK   = 3'd5;

  localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(DELAY_CYC - 1);
  localparam logic [TMR_W-1:0] RPT_LAST   = TMR_W'(RPT_CYC - 1);

  if (DELAY_CYC < 1 || RPT_CYC < 1 || ACCEL_AFTER < 0 ||
      DELAY_CYC > (2 ** TMR_W) || RPT_CYC > (2 ** TMR_W)) begin : g_bad_params
    $error("count_cmd_scheduler: parameter out of range");
  end

  logic [2:0]       state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [TMR_W-1:0] rpt_last;
  logic             up_prev, dn_prev;
  logic             up_rise, dn_rise;
  logic             in_hold, owner_up, owner_hi, other_hi;
  logic             up_cmd_nx, dn_cmd_nx, fire;

`ifdef COUNT_CMD_ACCEL_EN
  localparam int              FAST_CYC  = (RPT_CYC / 4 < 1) ? 1 : RPT_CYC / 4;
  localparam int              CNT_W     = (ACCEL_AFTER < 1) ? 1 : $clog2(ACCEL_AFTER + 1);
  localparam logic [TMR_W-1:0] FAST_LAST = TMR_W'(FAST_CYC - 1);
  localparam logic [CNT_W-1:0] ACCEL_N   = CNT_W'(ACCEL_AFTER);

  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nx;

  assign rpt_last = (rpt_cnt >= ACCEL_N) ? FAST_LAST : RPT_LAST;

  // Counts auto-repeat commands since the press was accepted, saturating at the threshold.
  always_comb begin
    rpt_cnt_nx = rpt_cnt;
    if (state == IDLE) begin
      rpt_cnt_nx = '0;
    end else if (fire && rpt_cnt != ACCEL_N) begin
      rpt_cnt_nx = rpt_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt_nx;
    end
  end
`else
  assign rpt_last = RPT_LAST;
`endif

  assign up_rise  = up_req & ~up_prev;
  assign dn_rise  = dn_req & ~dn_prev;
  assign in_hold  = (state == HOLD_UP) || (state == HOLD_DN);
  assign owner_up = (state == HOLD_UP) || (state == RPT_UP);
  assign owner_hi = owner_up ? up_req : dn_req;
  assign other_hi = owner_up ? dn_req : up_req;

  // Release and conflict are resolved before timer expiry is considered.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    up_cmd_nx = 1'b0;
    dn_cmd_nx = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (up_rise && dn_rise) begin
          state_nx = BLOCK;
        end else if (up_rise) begin
          up_cmd_nx = 1'b1;
          state_nx  = HOLD_UP;
        end else if (dn_rise) begin
          dn_cmd_nx = 1'b1;
          state_nx  = HOLD_DN;
        end
      end
      HOLD_UP, HOLD_DN, RPT_UP, RPT_DN: begin
        if (!owner_hi) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else if (other_hi) begin
          state_nx = BLOCK;
          timer_nx = '0;
        end else if (timer == (in_hold ? DELAY_LAST : rpt_last)) begin
          fire      = 1'b1;
          up_cmd_nx = owner_up;
          dn_cmd_nx = ~owner_up;
          state_nx  = owner_up ? RPT_UP : RPT_DN;
          timer_nx  = '0;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end
      BLOCK: begin
        timer_nx = '0;
        if (!up_req && !dn_req) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Previous-sample registers reset high so a request held through reset needs a re-press.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      up_prev    <= 1'b1;
      dn_prev    <= 1'b1;
      up_cmd     <= 1'b0;
      dn_cmd     <= 1'b0;
      busy       <= 1'b0;
      rpt_active <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      up_prev    <= up_req;
      dn_prev    <= dn_req;
      up_cmd     <= up_cmd_nx;
      dn_cmd     <= dn_cmd_nx;
      busy       <= (state_nx != IDLE);
      rpt_active <= (state_nx == RPT_UP) || (state_nx == RPT_DN);
    end
  end

endmodule
